// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one uart_tx among NUM_REQ byte streams with packet-locked round-robin arbitration.
// Latency: a byte is launched (tx_start) the cycle after it is accepted; back-to-back bytes of one packet launch every frame+3 cycles.
// Backpressure: a requester holds valid/data/last until its one-cycle req_ready pulse; a stalled lock owner is dropped after HOLD_TIMEOUT idle cycles.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset (shared with uart_tx)
//   req_valid/data/last    per-requester byte offer; requester i drives req_data[8i+7:8i]
//   req_ready              one-cycle accept pulse back to the requester whose byte was taken
//   tx_start, tx_data      launch pulse and byte to uart_tx; tx_data holds until the next launch
//   tx_busy                uart_tx frame in progress
//   grant_valid, grant_id  lock held / current or most recent owner (also the round-robin pointer)
//   bytes_sent             running count of launched bytes, wraps
//   timeout_pulse          one-cycle pulse when a stalled owner loses the lock
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 3,
    parameter int ID_WIDTH     = 2,
    parameter int HOLD_TIMEOUT = 4096,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   grant_valid,
    output logic [ID_WIDTH-1:0]    grant_id,
    output logic [CNT_WIDTH-1:0]   bytes_sent,
    output logic                   timeout_pulse
);

    localparam int HC_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
    localparam logic [HC_W-1:0]     HOLD_LAST = HC_W'(HOLD_TIMEOUT - 1);
    localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_WAIT   = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t               state, state_nxt;
    logic [HC_W-1:0]      hold_cnt, hold_cnt_nxt;
    logic                 last_flag, last_flag_nxt;
    logic [NUM_REQ-1:0]   req_ready_nxt;
    logic                 tx_start_nxt;
    logic [7:0]           tx_data_nxt;
    logic                 grant_valid_nxt;
    logic [ID_WIDTH-1:0]  grant_id_nxt;
    logic [CNT_WIDTH-1:0] bytes_sent_nxt;
    logic                 timeout_pulse_nxt;

    // Round-robin pick: first valid requester after the previous owner.
    logic                arb_found;
    logic [ID_WIDTH-1:0] arb_sel;

    always_comb begin
        arb_found = 1'b0;
        arb_sel   = grant_id;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!arb_found && req_valid[(int'(grant_id) + k) % NUM_REQ]) begin
                arb_found = 1'b1;
                arb_sel   = ID_WIDTH'((int'(grant_id) + k) % NUM_REQ);
            end
        end
    end

    // Candidate for capture: the arbitration winner when idle, otherwise the lock owner.
    logic [ID_WIDTH-1:0] cap_id;
    logic                cap_vld;
    logic [7:0]          cap_data;
    logic                cap_last;
    logic [NUM_REQ-1:0]  cap_onehot;

    always_comb begin
        cap_id     = (state == S_HOLD) ? grant_id : arb_sel;
        cap_vld    = 1'b0;
        cap_data   = 8'd0;
        cap_last   = 1'b0;
        cap_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (cap_id == ID_WIDTH'(i)) begin
                cap_vld       = req_valid[i];
                cap_data      = req_data[8*i +: 8];
                cap_last      = req_last[i];
                cap_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        logic capture;
        capture           = 1'b0;
        state_nxt         = state;
        hold_cnt_nxt      = hold_cnt;
        last_flag_nxt     = last_flag;
        req_ready_nxt     = '0;
        tx_start_nxt      = 1'b0;
        timeout_pulse_nxt = 1'b0;
        tx_data_nxt       = tx_data;
        grant_valid_nxt   = grant_valid;
        grant_id_nxt      = grant_id;
        bytes_sent_nxt    = bytes_sent;

        case (state)
            S_IDLE: begin
                if (!tx_busy && arb_found) begin
                    capture = 1'b1;
                end
            end
            // uart_tx raises busy one cycle after tx_start, so busy is meaningless here.
            S_SETTLE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!tx_busy) begin
                    if (last_flag) begin
                        // grant_id stays as the round-robin pointer.
                        grant_valid_nxt = 1'b0;
                        state_nxt       = S_IDLE;
                    end else begin
                        hold_cnt_nxt = '0;
                        state_nxt    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // A byte arriving on the terminal count wins over the timeout.
                if (cap_vld) begin
                    capture = 1'b1;
                end else if (hold_cnt == HOLD_LAST) begin
                    timeout_pulse_nxt = 1'b1;
                    grant_valid_nxt   = 1'b0;
                    state_nxt         = S_IDLE;
                end else begin
                    hold_cnt_nxt = hold_cnt + HC_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (capture) begin
            tx_data_nxt     = cap_data;
            tx_start_nxt    = 1'b1;
            req_ready_nxt   = cap_onehot;
            grant_id_nxt    = cap_id;
            grant_valid_nxt = 1'b1;
            last_flag_nxt   = cap_last;
            bytes_sent_nxt  = bytes_sent + CNT_WIDTH'(1);
            state_nxt       = S_SETTLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            hold_cnt      <= '0;
            last_flag     <= 1'b0;
            req_ready     <= '0;
            tx_start      <= 1'b0;
            tx_data       <= 8'd0;
            grant_valid   <= 1'b0;
            grant_id      <= LAST_ID;
            bytes_sent    <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            hold_cnt      <= hold_cnt_nxt;
            last_flag     <= last_flag_nxt;
            req_ready     <= req_ready_nxt;
            tx_start      <= tx_start_nxt;
            tx_data       <= tx_data_nxt;
            grant_valid   <= grant_valid_nxt;
            grant_id      <= grant_id_nxt;
            bytes_sent    <= bytes_sent_nxt;
            timeout_pulse <= timeout_pulse_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Purpose: scoreboard bench for uart_tx_arbiter with a behavioural uart_tx busy model.
// Latency: expected launches are queued by the stimulus; a negedge monitor pops one per tx_start.
// Backpressure: requester models hold each byte until req_ready, then advance or drop valid.
module tb_uart_tx_arbiter;

    localparam int NR    = 3;
    localparam int IDW   = 2;
    localparam int HT    = 16;
    localparam int CW    = 16;
    localparam int FRAME = 10;

    logic            clk;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            tx_start;
    logic [7:0]      tx_data;
    logic            tx_busy;
    logic            grant_valid;
    logic [IDW-1:0]  grant_id;
    logic [CW-1:0]   bytes_sent;
    logic            timeout_pulse;

    uart_tx_arbiter #(
        .NUM_REQ(NR), .ID_WIDTH(IDW), .HOLD_TIMEOUT(HT), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .bytes_sent(bytes_sent), .timeout_pulse(timeout_pulse)
    );

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [7:0]     data;
        logic [CW-1:0]  cnt;
    } exp_t;

    typedef logic [8:0] byte_q_t[$];

    exp_t    sb[$];
    byte_q_t rq[NR];
    int      cap_hist[$];
    int      checks, failures, cyc, exp_cnt, to_cnt, to_cyc, gv_fall_cyc, ucnt;
    int      rdy_cnt[NR];
    logic    gv_prev;
    exp_t    e;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic l);
        rq[r].push_back({l, d});
    endtask

    task automatic expect_byte(input int r, input logic [7:0] d);
        exp_t x;
        exp_cnt++;
        x.id   = IDW'(r);
        x.data = d;
        x.cnt  = CW'(exp_cnt);
        sb.push_back(x);
    endtask

    task automatic clear_model();
        for (int i = 0; i < NR; i++) begin
            rq[i].delete();
            rdy_cnt[i] = 0;
        end
        sb.delete();
        cap_hist.delete();
        exp_cnt     = 0;
        to_cnt      = 0;
        to_cyc      = -1;
        gv_fall_cyc = -1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"},     64'(req_ready),     64'd0);
        check({tag, "_tx_start"},      64'(tx_start),      64'd0);
        check({tag, "_tx_data"},       64'(tx_data),       64'd0);
        check({tag, "_grant_valid"},   64'(grant_valid),   64'd0);
        check({tag, "_grant_id"},      64'(grant_id),      64'(NR - 1));
        check({tag, "_bytes_sent"},    64'(bytes_sent),    64'd0);
        check({tag, "_timeout_pulse"}, 64'(timeout_pulse), 64'd0);
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check({name, "_drain_left"}, 64'(sb.size()), 64'd0);
    endtask

    // uart_tx model plus requester models, all updated away from the active edge.
    // Busy rises one cycle after tx_start and lasts FRAME cycles.
    initial begin
        ucnt      = 0;
        tx_busy   = 1'b0;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            if (reset)             ucnt = 0;
            else if (tx_start)     ucnt = FRAME + 1;
            else if (ucnt > 0)     ucnt--;
            tx_busy = (ucnt > 0) && (ucnt <= FRAME);
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]        = 1'b1;
                    req_last[i]         = rq[i][0][8];
                    req_data[8*i +: 8]  = rq[i][0][7:0];
                end else begin
                    req_valid[i]        = 1'b0;
                    req_last[i]         = 1'b0;
                    req_data[8*i +: 8]  = 8'd0;
                end
            end
        end
    end

    // Monitor: every launch must match the head of the scoreboard.
    initial begin
        gv_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (tx_start) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_launch: got data %0h id %0d, required none", tx_data, grant_id);
                    end else begin
                        logic [NR-1:0] oh;
                        e = sb.pop_front();
                        oh = '0;
                        oh[e.id] = 1'b1;
                        check("tx_data",     64'(tx_data),     64'(e.data));
                        check("grant_id",    64'(grant_id),    64'(e.id));
                        check("bytes_sent",  64'(bytes_sent),  64'(e.cnt));
                        check("req_ready",   64'(req_ready),   64'(oh));
                        check("grant_valid", 64'(grant_valid), 64'd1);
                    end
                    cap_hist.push_back(cyc);
                end
                if (timeout_pulse) begin
                    to_cnt++;
                    to_cyc = cyc;
                end
                for (int i = 0; i < NR; i++) if (req_ready[i]) rdy_cnt[i]++;
                if (gv_prev && !grant_valid) gv_fall_cyc = cyc;
            end
            gv_prev = grant_valid;
        end
    end

    initial begin
        int c0;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("por");
        reset = 1'b0;

        // Single 3-byte packet "AB\n" from requester 0.
        send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b0); send(0, 8'h0A, 1'b1);
        expect_byte(0, 8'h41); expect_byte(0, 8'h42); expect_byte(0, 8'h0A);
        wait_drain(200, "pkt3");
        repeat (20) @(posedge clk);
        #1;
        check("pkt3_ready_count", 64'(rdy_cnt[0]), 64'd3);
        check("pkt3_bytes_sent",  64'(bytes_sent), 64'd3);
        check("pkt3_launches",    64'(cap_hist.size()), 64'd3);
        if (cap_hist.size() == 3) begin
            check("pkt3_gap1",    64'(cap_hist[1] - cap_hist[0]), 64'(FRAME + 3));
            check("pkt3_gap2",    64'(cap_hist[2] - cap_hist[1]), 64'(FRAME + 3));
            check("pkt3_release", 64'(gv_fall_cyc), 64'(cap_hist[2] + FRAME + 2));
        end

        // Two simultaneous 2-byte packets: no interleaving, ids 0,0,1,1.
        do_reset();
        send(0, 8'h10, 1'b0); send(0, 8'h11, 1'b1);
        send(1, 8'h20, 1'b0); send(1, 8'h21, 1'b1);
        expect_byte(0, 8'h10); expect_byte(0, 8'h11);
        expect_byte(1, 8'h20); expect_byte(1, 8'h21);
        wait_drain(300, "pair");

        // Fairness: single-byte packets from everyone rotate 0,1,2,0,1,2.
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NR; i++) begin
                send(i, 8'h60 + 8'(3 * r + i), 1'b1);
                expect_byte(i, 8'h60 + 8'(3 * r + i));
            end
        end
        wait_drain(400, "rr");

        // Stall: requester 2 leaves mid-packet; requester 0 waits and then wins.
        do_reset();
        send(2, 8'h77, 1'b0);
        expect_byte(2, 8'h77);
        wait_drain(50, "stall_first");
        send(0, 8'h55, 1'b1);
        expect_byte(0, 8'h55);
        wait_drain(100, "stall_next");
        check("stall_timeouts", 64'(to_cnt), 64'd1);
        check("stall_launches", 64'(cap_hist.size()), 64'd2);
        if (cap_hist.size() == 2) begin
            check("stall_timeout_cycle", 64'(to_cyc),      64'(cap_hist[0] + FRAME + 2 + HT));
            check("stall_regrant_cycle", 64'(cap_hist[1]), 64'(cap_hist[0] + FRAME + 3 + HT));
        end

        // Owner's byte lands on the terminal hold count: launch, no timeout.
        do_reset();
        send(1, 8'h31, 1'b0);
        expect_byte(1, 8'h31);
        wait_drain(50, "edge_first");
        c0 = (cap_hist.size() > 0) ? cap_hist[0] : cyc;
        do begin
            @(posedge clk); #1;
        end while (cyc < c0 + FRAME + 1 + HT);
        send(1, 8'h32, 1'b1);
        expect_byte(1, 8'h32);
        wait_drain(10, "edge_second");
        repeat (30) @(posedge clk);
        #1;
        check("edge_timeouts", 64'(to_cnt), 64'd0);
        check("edge_launches", 64'(cap_hist.size()), 64'd2);
        if (cap_hist.size() == 2)
            check("edge_launch_cycle", 64'(cap_hist[1] - c0), 64'(FRAME + 2 + HT));

        // Reset during the second byte's frame, then a fresh request.
        do_reset();
        send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b0); send(0, 8'hA3, 1'b1);
        expect_byte(0, 8'hA1); expect_byte(0, 8'hA2);
        wait_drain(100, "mid_reset_pre");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        clear_model();
        @(posedge clk);
        #1;
        check_reset_values("mid");
        reset = 1'b0;
        send(1, 8'h5A, 1'b1);
        expect_byte(1, 8'h5A);
        wait_drain(50, "post_reset");
        check("post_reset_bytes_sent", 64'(bytes_sent), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance among NUM_REQ byte-stream requesters: the memory dumper, the CPU console, and the accelerator status reporter.
- Uses packet-locked round-robin arbitration. A requester keeps the UART from its first byte until it marks a byte with last, so multi-byte messages are never interleaved.
- Drives tx_start/tx_data into uart_tx and observes tx_busy.
- Recovers from a requester that stalls mid-packet via a timeout.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
ID_WIDTH, 2, width of grant_id; must satisfy 2**ID_WIDTH >= NUM_REQ
HOLD_TIMEOUT, 4096, cycles the lock owner may go without presenting a byte mid-packet before the lock is revoked
CNT_WIDTH, 16, width of bytes_sent

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte available
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  byte is final byte of requester's packet
req_ready  out  NUM_REQ  one-cycle pulse: byte from requester i accepted
tx_start  out  1  to uart_tx: start transmission, one-cycle pulse
tx_data  out  8  to uart_tx: byte, stable from tx_start until next tx_start
tx_busy  in  1  from uart_tx: transmitter active
grant_valid  out  1  a requester currently owns the UART
grant_id  out  ID_WIDTH  current or most recent owner
bytes_sent  out  CNT_WIDTH  total bytes launched; wraps modulo 2**CNT_WIDTH
timeout_pulse  out  1  one-cycle pulse when a lock is revoked by timeout

Behaviour:
- Reset values:
  - Outputs: req_ready=0, tx_start=0, tx_data=0, grant_valid=0, grant_id=NUM_REQ-1, bytes_sent=0, timeout_pulse=0.
  - Internal: state=S_IDLE, hold counter=0, last-flag=0.
- Reset mid-packet: abandon immediately, with no completion pulses. uart_tx shares the same reset.
- req_ready, tx_start and timeout_pulse default to 0 every cycle.
- Requester contract:
  - Hold req_valid, req_data and req_last stable until req_ready pulses.
  - On req_ready, advance to the next byte or deassert valid.
- States: S_IDLE, S_SETTLE, S_WAIT, S_HOLD.
- S_IDLE: arbitration.
  - When tx_busy=0 and any req_valid=1, select the first set requester scanning (grant_id+1) mod NUM_REQ upward with wrap. After reset this favours requester 0.
  - On the clock edge:
    - tx_data <= selected byte
    - tx_start <= 1
    - req_ready[sel] <= 1
    - grant_id <= sel
    - grant_valid <= 1
    - last-flag <= req_last[sel]
    - bytes_sent += 1
    - state goes to S_SETTLE
  - If nothing is pending, remain in S_IDLE.
- S_SETTLE: exactly one cycle; tx_busy is ignored (uart_tx raises busy one cycle after tx_start). Go to S_WAIT.
- S_WAIT: when tx_busy=0:
  - If last-flag=1: grant_valid <= 0 and go to S_IDLE. grant_id is kept as the round-robin pointer.
  - Otherwise: clear the hold counter and go to S_HOLD.
- S_HOLD: only the owner is considered; other requesters wait.
  - If req_valid[grant_id]=1: capture as in S_IDLE (same register updates, no arbitration) and go to S_SETTLE.
  - Else, if the hold counter equals HOLD_TIMEOUT-1: timeout_pulse <= 1, grant_valid <= 0, go to S_IDLE.
  - Else: increment the hold counter.
- Simultaneous events: if the owner's valid arrives in the same cycle the timeout would fire, the capture takes precedence and no timeout occurs.
- Throughput: one byte per (uart frame + 3) cycles. The owner's next byte can be launched in the cycle after S_WAIT exits.
- A single-byte packet (req_last=1 on its first byte) releases the lock immediately after its frame.
- Invalid grant_id values (NUM_REQ < 2**ID_WIDTH) are never produced.
- Any unreachable state encoding returns to S_IDLE.

Test Plan:
- Single requester 0 sends the 3-byte packet 0x41,0x42,0x0A (last on 0x0A):
  - UART emits "AB\n" in order.
  - Three req_ready pulses to requester 0, bytes_sent=3.
  - grant_valid falls after the third frame.
- Requesters 0 and 1 both present 2-byte packets in the same cycle after reset:
  - All of requester 0's packet is sent, then all of requester 1's; no interleaving.
  - grant_id sequence is 0,0,1,1.
- Fairness: all three requesters continuously present 1-byte packets → grants rotate 0,1,2,0,1,2 over six frames.
- Stall: requester 2 sends 1 byte without last and then drops valid, with HOLD_TIMEOUT=16:
  - timeout_pulse fires exactly 16 cycles after entering S_HOLD.
  - Requester 0, pending throughout, is granted next.
- Owner valid coincides with the terminal hold count → byte is launched and timeout_pulse stays 0.
- Assert reset during the second byte's frame:
  - All outputs return to reset values on the next edge.
  - After release, a fresh request from requester 1 is served with bytes_sent=1.
